// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
// MEM_WB_HILO_EN widens each stored entry with the HI/LO write path.
package mem_wb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Width of one GPR write-back channel: enable + address + data.
  function automatic int unsigned lane_w(input int unsigned addr_w,
                                         input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Flat width of one buffered entry (all lanes, plus HI/LO when enabled).
  function automatic int unsigned entry_w(input int unsigned lanes,
                                          input int unsigned addr_w,
                                          input int unsigned data_w);
`ifdef MEM_WB_HILO_EN
    return lanes * lane_w(addr_w, data_w) + 1 + 2 * data_w;
`else
    return lanes * lane_w(addr_w, data_w);
`endif
  endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One storage slot of the MEM->WB stage: flat register with
// synchronous clear (dominant) and load enable.
module mem_wb_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: LANES write-back channels behind a 2-entry skid
// buffer with valid/ready handshake and flush. MEM_WB_HILO_EN adds HI/LO.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_wreg,
  input  logic [LANES*ADDR_W-1:0]  in_waddr,
  input  logic [LANES*DATA_W-1:0]  in_wdata,
`ifdef MEM_WB_HILO_EN
  input  logic                     in_whilo,
  input  logic [DATA_W-1:0]        in_hi,
  input  logic [DATA_W-1:0]        in_lo,
  output logic                     out_whilo,
  output logic [DATA_W-1:0]        out_hi,
  output logic [DATA_W-1:0]        out_lo,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_wreg,
  output logic [LANES*ADDR_W-1:0]  out_waddr,
  output logic [LANES*DATA_W-1:0]  out_wdata
);

  localparam int unsigned ENTRY_W = entry_w(LANES, ADDR_W, DATA_W);
  localparam int unsigned DATA_L  = LANES * DATA_W;
  localparam int unsigned ADDR_L  = LANES * ADDR_W;
  localparam int unsigned GPR_W   = LANES + ADDR_L + DATA_L;

  state_t state;

  logic               accept;
  logic               pop;
  logic               clear;
  logic               main_load;
  logic               skid_load;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  // Handshake flags are pure decodes of the state register, so in_ready
  // has no path from out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign clear     = rst || flush;

  // Entry layout, LSB first: wdata lanes, waddr lanes, wreg lanes, [lo, hi, whilo].
`ifdef MEM_WB_HILO_EN
  assign in_entry = {in_whilo, in_hi, in_lo, in_wreg, in_waddr, in_wdata};
`else
  assign in_entry = {in_wreg, in_waddr, in_wdata};
`endif

  // MAIN takes the input when it is (or is about to be) free, or drains
  // SKID when a FULL stage is popped; SKID only catches the stalled entry.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    case (state)
      EMPTY: main_load = accept;
      ONE: begin
        main_load = accept && pop;
        skid_load = accept && !pop;
      end
      FULL: begin
        main_load = pop;
        main_d    = skid_q;
      end
      default: begin
        main_load = 1'b0;
        skid_load = 1'b0;
      end
    endcase
  end

  // Occupancy state; reset and flush both empty the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= ONE;
        end
        ONE: begin
          if (accept && !pop) begin
            state <= FULL;
          end else if (!accept && pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  mem_wb_slot #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .clear (clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  mem_wb_slot #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .clear (clear),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Enables are gated so a stale MAIN never issues a register write.
  assign out_wdata = main_q[DATA_L-1:0];
  assign out_waddr = main_q[DATA_L +: ADDR_L];
  assign out_wreg  = main_q[DATA_L+ADDR_L +: LANES] & {LANES{out_valid}};

`ifdef MEM_WB_HILO_EN
  assign out_lo    = main_q[GPR_W +: DATA_W];
  assign out_hi    = main_q[GPR_W+DATA_W +: DATA_W];
  assign out_whilo = main_q[GPR_W+2*DATA_W] & out_valid;
`else
  logic unused_gpr_w;
  assign unused_gpr_w = (GPR_W == ENTRY_W);
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe with LANES=2; exercises the
// HI/LO path as well when MEM_WB_HILO_EN is defined.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wreg;
  logic [9:0]  in_waddr;
  logic [63:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wreg;
  logic [9:0]  out_waddr;
  logic [63:0] out_wdata;
`ifdef MEM_WB_HILO_EN
  logic        in_whilo;
  logic [31:0] in_hi;
  logic [31:0] in_lo;
  logic        out_whilo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.ADDR_W(5), .DATA_W(32), .LANES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wreg   (in_wreg),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
`ifdef MEM_WB_HILO_EN
    .in_whilo  (in_whilo),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .out_whilo (out_whilo),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wreg  (out_wreg),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry n: lane0 addr n, data 0x11*n; lane1 addr n+16, data 0x100+n.
  task automatic put(input int n, input logic [1:0] wreg);
    in_valid = 1'b1;
    in_wreg  = wreg;
    in_waddr = {5'(n + 16), 5'(n)};
    in_wdata = {32'(32'h100 + n), 32'(32'h11 * n)};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_wreg  = 2'b00;
    in_waddr = '0;
    in_wdata = '0;
  endtask

  task automatic see(input string tag, input int n, input logic [1:0] wreg);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_wreg"},  64'(out_wreg),  64'(wreg));
    chk({tag, "_waddr"}, 64'(out_waddr), 64'({5'(n + 16), 5'(n)}));
    chk({tag, "_wdata"}, 64'(out_wdata), {32'(32'h100 + n), 32'(32'h11 * n)});
  endtask

  task automatic see_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_wreg"},  64'(out_wreg),  64'd0);
    chk({tag, "_waddr"}, 64'(out_waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(out_wdata), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready),  64'd1);
`ifdef MEM_WB_HILO_EN
    chk({tag, "_whilo"}, 64'(out_whilo), 64'd0);
    chk({tag, "_hi"},    64'(out_hi),    64'd0);
    chk({tag, "_lo"},    64'(out_lo),    64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
`ifdef MEM_WB_HILO_EN
    in_whilo = 1'b0;
    in_hi = '0;
    in_lo = '0;
`endif
    tick();
    tick();
    see_reset("reset");
    rst = 1'b0;

    // Streaming: each entry visible one cycle after acceptance.
    out_ready = 1'b1;
    put(1, 2'b11); tick(); see("s1", 1, 2'b11); chk("s1_ready", 64'(in_ready), 64'd1);
    put(2, 2'b11); tick(); see("s2", 2, 2'b11); chk("s2_ready", 64'(in_ready), 64'd1);
    put(3, 2'b11); tick(); see("s3", 3, 2'b11); chk("s3_ready", 64'(in_ready), 64'd1);
    put(4, 2'b11); tick(); see("s4", 4, 2'b11); chk("s4_ready", 64'(in_ready), 64'd1);

    // Backpressure: 5 goes to SKID, 6 waits upstream.
    out_ready = 1'b0;
    put(5, 2'b11); tick(); see("bp1", 4, 2'b11); chk("bp1_ready", 64'(in_ready), 64'd0);
    put(6, 2'b11); tick(); see("bp2", 4, 2'b11); chk("bp2_ready", 64'(in_ready), 64'd0);
    tick(); see("bp3", 4, 2'b11); chk("bp3_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick(); see("rel5", 5, 2'b11); chk("rel5_ready", 64'(in_ready), 64'd1);
    tick(); see("rel6", 6, 2'b11);
    idle();
    tick(); chk("drain_valid", 64'(out_valid), 64'd0); chk("drain_wreg", 64'(out_wreg), 64'd0);

    // Flush in FULL with input offered.
    out_ready = 1'b0;
    put(7, 2'b11); tick(); see("f7", 7, 2'b11);
    put(8, 2'b11); tick(); see("f8", 7, 2'b11); chk("f8_ready", 64'(in_ready), 64'd0);
    put(9, 2'b11); flush = 1'b1; tick();
    flush = 1'b0; idle();
    see_reset("flush_full");
    out_ready = 1'b1;
    tick(); chk("flush_full_after", 64'(out_valid), 64'd0);

    // Flush in ONE while an input would have been accepted.
    put(10, 2'b01); tick(); see("f10", 10, 2'b01);
    put(11, 2'b11); flush = 1'b1; tick();
    flush = 1'b0; idle();
    see_reset("flush_one");
    tick(); chk("flush_one_after", 64'(out_valid), 64'd0);

    // Reset together with flush while FULL.
    out_ready = 1'b0;
    put(12, 2'b11); tick();
    put(13, 2'b11); tick(); chk("r_full_ready", 64'(in_ready), 64'd0);
    idle(); rst = 1'b1; flush = 1'b1; tick();
    rst = 1'b0; flush = 1'b0;
    see_reset("rst_full");
    tick(); chk("rst_after", 64'(out_valid), 64'd0);

    // Write-enable gating.
    out_ready = 1'b1;
    put(14, 2'b10); tick(); see("g14", 14, 2'b10);
    idle(); tick();
    chk("gate_valid", 64'(out_valid), 64'd0);
    chk("gate_wreg", 64'(out_wreg), 64'd0);

`ifdef MEM_WB_HILO_EN
    // HI/LO travels with its GPR lanes through SKID.
    out_ready = 1'b0;
    put(20, 2'b11); in_whilo = 1'b1; in_hi = 32'hDEADBEEF; in_lo = 32'h12345678; tick();
    put(21, 2'b01); in_whilo = 1'b0; in_hi = 32'h1; in_lo = 32'h2; tick();
    idle(); in_whilo = 1'b0; in_hi = '0; in_lo = '0;
    see("h20", 20, 2'b11);
    chk("h20_whilo", 64'(out_whilo), 64'd1);
    chk("h20_hi", 64'(out_hi), 64'hDEADBEEF);
    chk("h20_lo", 64'(out_lo), 64'h12345678);
    out_ready = 1'b1;
    tick(); see("h21", 21, 2'b01);
    chk("h21_whilo", 64'(out_whilo), 64'd0);
    chk("h21_hi", 64'(out_hi), 64'h1);
    chk("h21_lo", 64'(out_lo), 64'h2);
    tick();
    chk("h_drain_valid", 64'(out_valid), 64'd0);
    chk("h_drain_whilo", 64'(out_whilo), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline stage for the OpenMIPS core, replacing the fixed single-port MEM/WB register. It carries `LANES` independent register-write channels from the memory stage to write-back. It adds a valid/ready handshake, a 2-entry skid buffer so upstream ready never depends combinationally on downstream ready, and a synchronous flush. It sits between the `mem` stage and the register file write port(s).

## Interface
- `ADDR_W`, 5, register address width per lane
- `DATA_W`, 32, write data width per lane
- `LANES`, 1, number of parallel write-back channels (1..4)
- `clk  in  1  clock, all state updates on rising edge`
- `rst  in  1  reset rst, synchronous, active-high; clock clk`
- `flush  in  1  synchronous discard of all buffered entries and the current input`
- `in_valid  in  1  upstream entry present`
- `in_ready  out  1  stage can accept; decoded from state register only`
- `in_wreg  in  LANES  per-lane write enable`
- `in_waddr  in  LANES*ADDR_W  per-lane destination, lane 0 in LSBs`
- `in_wdata  in  LANES*DATA_W  per-lane data, lane 0 in LSBs`
- `out_valid  out  1  head entry present`
- `out_ready  in  1  write-back consumes head`
- `out_wreg  out  LANES  head write enables, forced 0 when !out_valid`
- `out_waddr  out  LANES*ADDR_W  head destinations`
- `out_wdata  out  LANES*DATA_W  head data`

## Operation
- Storage: MAIN slot (drives outputs) and SKID slot. The states are EMPTY (none valid), ONE (MAIN valid), and FULL (both valid).
- Accept = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- EMPTY: accept → load MAIN, go to ONE.
- ONE, accept and pop → load MAIN, stay in ONE.
- ONE, accept only → load SKID, go to FULL.
- ONE, pop only → go to EMPTY.
- FULL: `in_ready=0`. Pop → MAIN←SKID, go to ONE. Otherwise hold.
- `in_ready = (state != FULL)`. There is no combinational path from `out_ready`.
- Entries leave in arrival order, with no loss and no duplication.
- Flush: next state is EMPTY, and a simultaneous accept is dropped. An entry popped in the flush cycle counts as consumed.
- `rst` has priority over `flush`.
- Lanes are carried verbatim. Same-address conflicts between lanes are not resolved here; the write-back stage gives the higher lane priority.
- Address or data with `wreg=0` pass through unchanged, but are don't-care downstream.

## Timing
- Reset / flush values: state EMPTY, `out_valid=0`, `out_wreg=0`, `out_waddr`=NOPRegAddr (0), `out_wdata`=ZeroWord (0), SKID cleared. `in_ready=1` from the first cycle after reset.
- Latency is 1 cycle, input to `out_valid`, when EMPTY or ONE-with-pop.
- Throughput is 1 entry/cycle while `out_ready=1`.
- After `out_ready` drops, at most one more entry is accepted (into SKID). `in_ready` falls the cycle after FULL is entered.
- Recovery from FULL: the first pop makes `in_ready=1` on the following cycle.
- Outputs change only on clock edges, and are held stable while `out_valid && !out_ready`.

## Configuration
- `MEM_WB_HILO_EN` defined: adds the HI/LO path.
  - Ports `in_whilo` (1), `in_hi`/`in_lo` (DATA_W), `out_whilo`, `out_hi`, `out_lo`.
  - These travel in the same slots with identical handshake, flush and reset (`out_whilo=0`, hi/lo=0). `out_whilo` is forced 0 when `!out_valid`.
- Undefined: those ports and that storage do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `mem_wb_pkg`:
  - default `ADDR_W`/`DATA_W`
  - `NOP_REG_ADDR`, `ZERO_WORD`
  - state enum {EMPTY, ONE, FULL}
  - entry struct-width helper `ENTRY_W = LANES*(1+ADDR_W+DATA_W)` (+`1+2*DATA_W` with HILO)
- One sub-module, `mem_wb_slot`: a flat `ENTRY_W` register with synchronous clear and load enable. It is instantiated twice (MAIN, SKID).
- Top level holds the state register, next-state logic and packing/unpacking.

## Test plan
- Reset then stream: `LANES=2`, `out_ready=1`, 4 back-to-back entries (waddr 1..4, wdata 0x11..0x44). Each appears exactly 1 cycle later, in order; `in_ready` stays 1.
- Backpressure: drop `out_ready` for 3 cycles mid-stream. Exactly one extra entry is taken into SKID, `in_ready`=0 from the next cycle, and no entry is lost or duplicated after release.
- Flush in FULL: assert `flush` with `in_valid=1`. Next cycle `out_valid=0`, outputs zero, `in_ready=1`, and the flush-cycle input never appears.
- Reset mid-operation: assert `rst` while FULL. Next cycle all outputs are at reset values; `rst`+`flush` together behaves as reset.
- Gating: entry with `wreg=0b10`, then `out_valid=0`. `out_wreg` shows 0b10, then 0b00, regardless of stale address/data.
- With `MEM_WB_HILO_EN`: `in_whilo=1`, hi=0xDEADBEEF, lo=0x12345678 under backpressure. Delivered intact and in order with its GPR lanes.
